// File: rtl/fb_scanout.sv
// Line scan-out engine: fetches WORDS_PER_LINE 32-bit words from a framebuffer port
// whose nibbles refresh in counter order, and shifts the pixels out LSB-first on pix_en.
module fb_scanout #(
    parameter int ADDR_BITS      = 4,
    parameter int WORDS_PER_LINE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           counter,
    input  logic                 line_start,
    input  logic [ADDR_BITS-1:0] line_base,
    input  logic                 pix_en,
    output logic [ADDR_BITS-1:0] r_addr,
    input  logic [31:0]          r_data,
    output logic                 pixel,
    output logic                 busy,
    output logic                 underrun
);

    localparam int IDX_BITS = $clog2(WORDS_PER_LINE + 1);

    typedef enum logic [2:0] {IDLE, ALIGN, FETCH, CAPTURE, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_BITS-1:0] base;
    logic [IDX_BITS-1:0]  index;
    logic [31:0]          pf_buf;
    logic                 pf_valid;
    logic [31:0]          shift;
    logic [5:0]           count;

    logic consume;
    logic load;
    logic capture;
    logic last_word;
    logic line_done;
    logic starve;

    // The shifter empties this edge if it is already empty or its last bit is being strobed.
    assign consume   = pix_en && (count != 6'd0);
    assign load      = pf_valid && ((count == 6'd0) || (count == 6'd1 && pix_en));
    assign capture   = (state == CAPTURE) && (!pf_valid || load);
    assign last_word = (int'(index) + 1) >= WORDS_PER_LINE;
    assign line_done = ((state == IDLE) || (state == DONE)) && !pf_valid;
    assign starve    = pix_en && (count == 6'd0) && !line_done;

    assign r_addr   = base + ADDR_BITS'(index);
    assign pixel    = (count != 6'd0) && shift[0];
    assign busy     = (state != IDLE) && (state != DONE);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt; otherwise a latch is inferred.
        state_nxt = state;
        case (state)
            ALIGN:   if (counter == 3'd7) state_nxt = FETCH;
            FETCH:   if (counter == 3'd7) state_nxt = CAPTURE;
            CAPTURE: if (capture) state_nxt = last_word ? DONE : ALIGN;
            default: state_nxt = state;
        endcase
        if (line_start) state_nxt = ALIGN;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base     <= '0;
            index    <= '0;
            pf_buf   <= '0;
            pf_valid <= 1'b0;
            shift    <= '0;
            count    <= '0;
            underrun <= 1'b0;
        end else if (line_start) begin
            // A new line discards anything captured or loaded on this same edge.
            base     <= line_base;
            index    <= '0;
            pf_buf   <= '0;
            pf_valid <= 1'b0;
            shift    <= '0;
            count    <= '0;
        end else begin
            if (load) begin
                shift <= pf_buf;
                count <= 6'd32;
            end else if (consume) begin
                shift <= {1'b0, shift[31:1]};
                count <= count - 6'd1;
            end

            if (capture) begin
                pf_buf   <= r_data;
                pf_valid <= 1'b1;
                index    <= index + 1'b1;
            end else if (load) begin
                pf_valid <= 1'b0;
            end

            if (starve) underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: a nibble-rotating framebuffer model feeds two instances
// (2 and 3 words per line) driven by the same line/pixel stimulus.
module tb_fb_scanout;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  counter = 3'd0;
    logic        line_start = 1'b0;
    logic [3:0]  line_base = 4'd0;
    logic        pix_en = 1'b0;
    logic [3:0]  r_addr, r_addr3;
    logic [31:0] r_data = '0;
    logic [31:0] r_data3 = '0;
    logic        pixel, busy, underrun;
    logic        pixel3, busy3, underrun3;

    logic [31:0] mem [16];
    logic [63:0] line_bits = 64'h8000_0001_A5A5_0F0F;

    int checks = 0;
    int errors = 0;

    fb_scanout #(.ADDR_BITS(4), .WORDS_PER_LINE(2)) dut (
        .clk(clk), .rst_n(rst_n), .counter(counter), .line_start(line_start),
        .line_base(line_base), .pix_en(pix_en), .r_addr(r_addr), .r_data(r_data),
        .pixel(pixel), .busy(busy), .underrun(underrun)
    );

    fb_scanout #(.ADDR_BITS(4), .WORDS_PER_LINE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .counter(counter), .line_start(line_start),
        .line_base(line_base), .pix_en(pix_en), .r_addr(r_addr3), .r_data(r_data3),
        .pixel(pixel3), .busy(busy3), .underrun(underrun3)
    );

    always #5 clk = ~clk;

    // Free-running phase and framebuffer: nibble k refreshes at the end of a counter==k cycle.
    always @(posedge clk) begin
        counter <= counter + 3'd1;
        r_data[counter*4 +: 4]  <= mem[r_addr][counter*4 +: 4];
        r_data3[counter*4 +: 4] <= mem[r_addr3][counter*4 +: 4];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cnt(input logic [2:0] k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (counter != k && n < 20);
        check("wait_counter", 32'(counter), 32'(k));
    endtask

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 32'h0;
        mem[3]  = 32'hA5A5_0F0F;
        mem[4]  = 32'h8000_0001;
        mem[15] = 32'h1234_5678;
        mem[0]  = 32'hDEAD_BEEF;
        mem[1]  = 32'h0000_0002;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_r_addr", 32'(r_addr), 0);
        check("rst_pixel", 32'(pixel), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_count", 32'(dut.count), 0);
        check("rst_pf_valid", 32'(dut.pf_valid), 0);
        check("rst_index", 32'(dut.index), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_rst", 32'(busy), 0);

        // Line at base 3, started with counter==2
        wait_cnt(3'd2);
        line_start = 1'b1;
        line_base  = 4'd3;
        @(negedge clk);
        line_start = 1'b0;
        check("align_busy", 32'(busy), 1);
        check("align_addr", 32'(r_addr), 3);
        wait_cnt(3'd0);
        check("fetch0_addr_c0", 32'(r_addr), 3);
        wait_cnt(3'd7);
        check("fetch0_addr_c7", 32'(r_addr), 3);
        wait_cnt(3'd0);
        check("capture0_addr", 32'(r_addr), 3);
        check("capture0_pf_empty", 32'(dut.pf_valid), 0);
        @(negedge clk);
        check("after_cap_addr", 32'(r_addr), 4);
        check("after_cap_pf", 32'(dut.pf_valid), 1);
        check("before_load_pixel", 32'(pixel), 0);
        @(negedge clk);
        check("load_count", 32'(dut.count), 32);
        check("load_pf_clear", 32'(dut.pf_valid), 0);
        check("fill_underrun", 32'(underrun), 0);

        // 64 strobes LSB-first across both words
        pix_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("pix%0d", i), 32'(pixel), 32'(line_bits[i]));
        end
        @(negedge clk);
        check("line_end_pixel", 32'(pixel), 0);
        repeat (2) @(negedge clk);
        check("line_end_underrun", 32'(underrun), 0);
        check("line_end_busy", 32'(busy), 0);

        // pix_en high straight after line_start starves the shifter
        line_start = 1'b1;
        line_base  = 4'd3;
        @(negedge clk);
        line_start = 1'b0;
        @(negedge clk);
        check("starve_underrun", 32'(underrun), 1);
        check("starve_pixel", 32'(pixel), 0);
        repeat (3) @(negedge clk);
        check("starve_pixel_late", 32'(pixel), 0);
        pix_en = 1'b0;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        @(negedge clk);
        check("underrun_sticky", 32'(underrun), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("underrun_rst", 32'(underrun), 0);
        rst_n = 1'b1;

        // Base 3 again; restart with base 15 during FETCH of word 1
        wait_cnt(3'd2);
        line_start = 1'b1;
        line_base  = 4'd3;
        @(negedge clk);
        line_start = 1'b0;
        wait_cnt(3'd0);
        wait_cnt(3'd0);
        wait_cnt(3'd0);
        wait_cnt(3'd4);
        check("w1_fetch_addr", 32'(r_addr), 4);
        check("w1_fetch_count", 32'(dut.count), 32);
        line_start = 1'b1;
        line_base  = 4'd15;
        @(negedge clk);
        line_start = 1'b0;
        check("restart_addr", 32'(r_addr), 15);
        check("restart_count", 32'(dut.count), 0);
        check("restart_pf", 32'(dut.pf_valid), 0);
        check("restart_busy", 32'(busy), 1);
        check("restart_index", 32'(dut.index), 0);

        // Base 15: second fetch wraps to address 0
        wait_cnt(3'd0);
        check("b15_fetch0", 32'(r_addr), 15);
        wait_cnt(3'd0);
        check("b15_capture0", 32'(r_addr), 15);
        wait_cnt(3'd0);
        check("wrap_addr", 32'(r_addr), 0);
        check("wrap_addr3", 32'(r_addr3), 0);
        wait_cnt(3'd0);
        wait_cnt(3'd0);
        check("w2_done_busy", 32'(busy), 0);
        check("w2_done_pf", 32'(dut.pf_valid), 1);
        check("w2_done_count", 32'(dut.count), 32);
        check("w3_fetch_addr", 32'(r_addr3), 1);

        // Three-word instance: third word waits in CAPTURE until the shifter empties
        wait_cnt(3'd0);
        wait_cnt(3'd5);
        check("wait_busy3", 32'(busy3), 1);
        check("wait_addr3", 32'(r_addr3), 1);
        check("wait_pf3", 32'(dut3.pf_valid), 1);
        check("wait_count3", 32'(dut3.count), 32);
        check("wait_pixel3", 32'(pixel3), 0);
        pix_en = 1'b1;
        repeat (31) @(negedge clk);
        check("pre_empty_count3", 32'(dut3.count), 1);
        check("pre_empty_busy3", 32'(busy3), 1);
        @(negedge clk);
        check("empty_count3", 32'(dut3.count), 32);
        check("empty_pf3", 32'(dut3.pf_valid), 1);
        check("empty_busy3", 32'(busy3), 0);
        check("empty_pixel3", 32'(pixel3), 1);
        check("empty_pixel", 32'(pixel), 1);
        check("empty_pf", 32'(dut.pf_valid), 0);
        pix_en = 1'b0;

        // Reset pulse mid-FETCH
        line_start = 1'b1;
        line_base  = 4'd3;
        pix_en     = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        wait_cnt(3'd0);
        wait_cnt(3'd3);
        check("midfetch_underrun", 32'(underrun), 1);
        check("midfetch_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_r_addr", 32'(r_addr), 0);
        check("abort_pixel", 32'(pixel), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_underrun", 32'(underrun), 0);
        pix_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_abort_busy", 32'(busy), 0);
        check("post_abort_addr", 32'(r_addr), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
